// File: rtl/mpu_alu_arb.sv
`default_nettype none
// ============================================================================
// Module   : mpu_alu_arb
// Purpose  : Two-requester round-robin arbiter and sequencer in front of the
//            shared combinational mpu_alu. A granted command is held in a
//            command register and drives the ALU for exactly one cycle (EXEC).
//            The ALU result and flags are then registered, and a one-cycle ack
//            is returned to the granted requester (DONE).
//
// Ports    :
//   sys_clk, sys_rst_n       clock, synchronous active-low reset
//   a_stb / a_cmd / a_ack    requester A: valid, packed command, completion
//   b_stb / b_cmd / b_ack    requester B: valid, packed command, completion
//   res, flags               registered result/flags of last completed op
//   busy                     high whenever the sequencer is not idle
//   op_cnt                   completed-operation count (wraps)
//   alu_*                    operand/control fields driven to mpu_alu
//   alu_res, alu_flags       combinational result returned by mpu_alu
//
// Command layout (210 bits):
//   [209:206] op  [205:204] size  [203:140] o2  [139:76] o1  [75:12] o0
//   [11:9] s0  [8:6] s1  [5:3] s2  [2:0] sres
//
// Revision : 1.0  initial release
// ============================================================================
module mpu_alu_arb #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,

  input  logic             a_stb,
  input  logic [209:0]     a_cmd,
  output logic             a_ack,

  input  logic             b_stb,
  input  logic [209:0]     b_cmd,
  output logic             b_ack,

  output logic [63:0]      res,
  output logic [7:0]       flags,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt,

  output logic [3:0]       alu_op,
  output logic [1:0]       alu_size,
  output logic [63:0]      alu_o0,
  output logic [63:0]      alu_o1,
  output logic [63:0]      alu_o2,
  output logic [2:0]       alu_s0,
  output logic [2:0]       alu_s1,
  output logic [2:0]       alu_s2,
  output logic [2:0]       alu_sres,
  input  logic [63:0]      alu_res,
  input  logic [7:0]       alu_flags
);

  localparam int         c_CMD_W   = 210;
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_EXEC = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;

  logic [c_CMD_W-1:0] r_cmd;
  logic               r_gnt_b;    // current operation belongs to B
  logic               r_last_b;   // last grant went to B (round-robin pointer)
  logic [63:0]        r_res;
  logic [7:0]         r_flags;
  logic [CNT_W-1:0]   r_op_cnt;

  logic               w_any_req;
  logic               w_pick_b;
  logic               w_grant;

  // --------------------------------------------------------------------------
  // Arbitration: a lone requester always wins; on a tie the requester that
  // was not served last wins. The pointer resets to B so A wins the first tie.
  // --------------------------------------------------------------------------
  assign w_any_req = a_stb | b_stb;
  assign w_pick_b  = b_stb & (~a_stb | ~r_last_b);
  assign w_grant   = (r_state == c_ST_IDLE) & w_any_req;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: if (w_any_req) w_next_state = c_ST_EXEC;
      c_ST_EXEC: w_next_state = c_ST_DONE;
      c_ST_DONE: w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Acks decode directly from registered state, so they are
  // clean one-cycle pulses aligned with DONE.
  // --------------------------------------------------------------------------
  always_comb begin
    busy  = 1'b0;
    a_ack = 1'b0;
    b_ack = 1'b0;
    case (r_state)
      c_ST_IDLE: busy = 1'b0;
      c_ST_EXEC: busy = 1'b1;
      c_ST_DONE: begin
        busy  = 1'b1;
        a_ack = ~r_gnt_b;
        b_ack = r_gnt_b;
      end
      default:   busy = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath. The command register loads only on the grant edge, which
  // isolates the ALU from any later change on a_cmd/b_cmd.
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_cmd    <= '0;
      r_gnt_b  <= 1'b0;
      r_last_b <= 1'b1;
      r_res    <= '0;
      r_flags  <= '0;
      r_op_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_cmd    <= w_pick_b ? b_cmd : a_cmd;
        r_gnt_b  <= w_pick_b;
        r_last_b <= w_pick_b;
      end
      if (r_state == c_ST_EXEC) begin
        r_res    <= alu_res;
        r_flags  <= alu_flags;
        r_op_cnt <= r_op_cnt + 1'b1;   // natural wrap at 2^CNT_W
      end
    end
  end

  // --------------------------------------------------------------------------
  // ALU drive: pure field split of the command register
  // --------------------------------------------------------------------------
  assign alu_op   = r_cmd[209:206];
  assign alu_size = r_cmd[205:204];
  assign alu_o2   = r_cmd[203:140];
  assign alu_o1   = r_cmd[139:76];
  assign alu_o0   = r_cmd[75:12];
  assign alu_s0   = r_cmd[11:9];
  assign alu_s1   = r_cmd[8:6];
  assign alu_s2   = r_cmd[5:3];
  assign alu_sres = r_cmd[2:0];

  assign res    = r_res;
  assign flags  = r_flags;
  assign op_cnt = r_op_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mpu_alu_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpu_alu_arb
// Purpose  : Self-checking bench for mpu_alu_arb. A stand-in ALU mixes every
//            command field into res/flags so that any mis-routed field shows
//            up in the returned values. Completions are checked against a
//            queue of expected commands filled when requests are issued.
// Revision : 1.0  initial release
// ============================================================================
module tb_mpu_alu_arb;

  localparam int CNT_W = 2;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             a_stb, b_stb;
  logic [209:0]     a_cmd, b_cmd;
  logic             a_ack, b_ack;
  logic [63:0]      res;
  logic [7:0]       flags;
  logic             busy;
  logic [CNT_W-1:0] op_cnt;
  logic [3:0]       alu_op;
  logic [1:0]       alu_size;
  logic [63:0]      alu_o0, alu_o1, alu_o2;
  logic [2:0]       alu_s0, alu_s1, alu_s2, alu_sres;
  logic [63:0]      alu_res;
  logic [7:0]       alu_flags;

  mpu_alu_arb #(.CNT_W(CNT_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .a_stb     (a_stb),
    .a_cmd     (a_cmd),
    .a_ack     (a_ack),
    .b_stb     (b_stb),
    .b_cmd     (b_cmd),
    .b_ack     (b_ack),
    .res       (res),
    .flags     (flags),
    .busy      (busy),
    .op_cnt    (op_cnt),
    .alu_op    (alu_op),
    .alu_size  (alu_size),
    .alu_o0    (alu_o0),
    .alu_o1    (alu_o1),
    .alu_o2    (alu_o2),
    .alu_s0    (alu_s0),
    .alu_s1    (alu_s1),
    .alu_s2    (alu_s2),
    .alu_sres  (alu_sres),
    .alu_res   (alu_res),
    .alu_flags (alu_flags)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic [209:0] mk_cmd(input logic [3:0] op, input logic [1:0] sz,
                                          input logic [63:0] o2, input logic [63:0] o1,
                                          input logic [63:0] o0, input logic [2:0] s0,
                                          input logic [2:0] s1, input logic [2:0] s2,
                                          input logic [2:0] sr);
    return {op, sz, o2, o1, o0, s0, s1, s2, sr};
  endfunction

  function automatic logic [63:0] f_res(input logic [209:0] c);
    logic [63:0] o0, o1, o2;
    logic [5:0]  hi, lo;
    o2 = c[203:140];
    o1 = c[139:76];
    o0 = c[75:12];
    hi = c[209:204];
    lo = c[11:6];
    return (o0 + {o1[62:0], 1'b0}) ^ o2 ^ {52'd0, hi, lo};
  endfunction

  function automatic logic [7:0] f_flags(input logic [209:0] c);
    logic [63:0] r;
    r = f_res(c);
    return {c[209:206], c[205:204], 2'b00} ^ {2'b00, c[5:0]} ^ r[7:0];
  endfunction

  // Stand-in mpu_alu
  always_comb begin
    alu_res   = f_res({alu_op, alu_size, alu_o2, alu_o1, alu_o0, alu_s0, alu_s1, alu_s2, alu_sres});
    alu_flags = f_flags({alu_op, alu_size, alu_o2, alu_o1, alu_o0, alu_s0, alu_s1, alu_s2, alu_sres});
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard: expected completions in order; checked whenever an ack shows
  // --------------------------------------------------------------------------
  typedef struct {
    bit           is_b;
    logic [209:0] cmd;
  } exp_t;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  always @(negedge sys_clk) begin
    exp_t e;
    if (!sys_rst_n) begin
      exp_cnt = '0;
      sb.delete();
    end else if (a_ack || b_ack) begin
      if (a_ack && b_ack) chk("ack_onehot", 64'(a_ack) + 64'(b_ack), 64'd1);
      if (sb.size() == 0) begin
        chk("sb_depth_at_ack", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        exp_cnt = exp_cnt + 1'b1;
        chk("ack_is_b",   64'(b_ack),  64'(e.is_b));
        chk("res",        res,         f_res(e.cmd));
        chk("flags",      64'(flags),  64'(f_flags(e.cmd)));
        chk("op_cnt",     64'(op_cnt), 64'(exp_cnt));
        chk("alu_op",     64'(alu_op), 64'(e.cmd[209:206]));
        chk("alu_o0",     alu_o0,      e.cmd[75:12]);
        chk("alu_sres",   64'(alu_sres), 64'(e.cmd[2:0]));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic reset_dut();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    a_stb     = 1'b0;
    b_stb     = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  // Issue requests on A and/or B and hold each until its ack is seen.
  task automatic run_req(input bit ar, input bit br, input logic [209:0] ac,
                         input logic [209:0] bc, input bit first_b);
    int need, got, ta, tb, budget;
    exp_t e;
    @(negedge sys_clk);
    a_cmd = ac;
    b_cmd = bc;
    a_stb = ar;
    b_stb = br;
    need  = int'(ar) + int'(br);
    if (ar && br) begin
      e.is_b = first_b;  e.cmd = first_b ? bc : ac;  sb.push_back(e);
      e.is_b = !first_b; e.cmd = first_b ? ac : bc;  sb.push_back(e);
    end else begin
      e.is_b = br;       e.cmd = br ? bc : ac;       sb.push_back(e);
    end
    got = 0; ta = 0; tb = 0; budget = 20;
    while (got < need && budget > 0) begin
      @(negedge sys_clk);
      budget--;
      if (a_ack) begin a_stb = 1'b0; got++; ta = cyc; end
      if (b_ack) begin b_stb = 1'b0; got++; tb = cyc; end
    end
    if (got < need) chk("ack_timeout", 64'(got), 64'(need));
    if (ar && br) chk("tie_ack_spacing", 64'(first_b ? ta - tb : tb - ta), 64'd3);
  endtask

  typedef struct {
    bit           a_req;
    bit           b_req;
    logic [209:0] a_cmd;
    logic [209:0] b_cmd;
    bit           exp_first_b;
  } vec_t;

  vec_t tbl[7];

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [209:0] c;
    int           budget;

    sys_rst_n = 1'b0;
    a_stb = 1'b0; b_stb = 1'b0;
    a_cmd = '0;   b_cmd = '0;

    // Tie pattern after a fresh reset: pointer starts at B, so A wins first.
    tbl[0] = '{1'b1, 1'b1, mk_cmd(4'd2, 2'd1, 64'h11, 64'h22, 64'h33, 3'd1, 3'd2, 3'd3, 3'd4),
                            mk_cmd(4'd1, 2'd2, 64'h44, 64'h55, 64'h66, 3'd5, 3'd6, 3'd7, 3'd1), 1'b0};
    tbl[1] = '{1'b1, 1'b1, mk_cmd(4'd5, 2'd3, 64'hDEAD_BEEF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 3'd7, 3'd0, 3'd7),
                            mk_cmd(4'd9, 2'd0, 64'h0, 64'h8000_0000_0000_0000, 64'h7, 3'd2, 3'd2, 3'd2, 3'd2), 1'b0};
    tbl[2] = '{1'b1, 1'b1, mk_cmd(4'd15, 2'd1, 64'h5, 64'h6, 64'h7, 3'd3, 3'd4, 3'd5, 3'd6),
                            mk_cmd(4'd14, 2'd2, 64'h8, 64'h9, 64'hA, 3'd6, 3'd5, 3'd4, 3'd3), 1'b0};
    tbl[3] = '{1'b0, 1'b1, '0, mk_cmd(4'd7, 2'd3, 64'h123, 64'h456, 64'h789, 3'd1, 3'd1, 3'd1, 3'd1), 1'b1};
    tbl[4] = '{1'b1, 1'b0, mk_cmd(4'd8, 2'd0, 64'hABC, 64'hDEF, 64'h0F0, 3'd2, 3'd3, 3'd4, 3'd5), '0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, mk_cmd(4'd4, 2'd2, 64'h1000, 64'h2000, 64'h3000, 3'd7, 3'd0, 3'd7, 3'd0),
                            mk_cmd(4'd6, 2'd1, 64'h4000, 64'h5000, 64'h6000, 3'd0, 3'd7, 3'd0, 3'd7), 1'b1};
    tbl[6] = '{1'b1, 1'b0, mk_cmd(4'd10, 2'd3, 64'hCAFE, 64'hF00D, 64'hBEEF, 3'd4, 3'd4, 3'd4, 3'd4), '0, 1'b0};

    // Reset values
    reset_dut();
    @(negedge sys_clk);
    chk("rst_busy",   64'(busy),   64'd0);
    chk("rst_a_ack",  64'(a_ack),  64'd0);
    chk("rst_b_ack",  64'(b_ack),  64'd0);
    chk("rst_res",    res,         64'd0);
    chk("rst_flags",  64'(flags),  64'd0);
    chk("rst_op_cnt", 64'(op_cnt), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_alu_o0", alu_o0,      64'd0);

    // Single A request with cycle-exact latency
    c = mk_cmd(4'd3, 2'd0, 64'd0, 64'h55, 64'h54, 3'd0, 3'd0, 3'd0, 3'd0);
    a_cmd = c;
    a_stb = 1'b1;
    sb.push_back('{1'b0, c});
    @(negedge sys_clk);                       // EXEC
    chk("exec_busy",   64'(busy),   64'd1);
    chk("exec_a_ack",  64'(a_ack),  64'd0);
    chk("exec_alu_op", 64'(alu_op), 64'd3);
    chk("exec_alu_o0", alu_o0,      64'h54);
    @(negedge sys_clk);                       // DONE
    chk("done_a_ack",  64'(a_ack),  64'd1);
    chk("done_b_ack",  64'(b_ack),  64'd0);
    a_stb = 1'b0;
    @(negedge sys_clk);                       // back to IDLE
    chk("idle_a_ack",  64'(a_ack),  64'd0);
    chk("idle_busy",   64'(busy),   64'd0);
    chk("hold_res",    res,         f_res(c));

    // Arbitration table, starting from a fresh pointer
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      run_req(tbl[i].a_req, tbl[i].b_req, tbl[i].a_cmd, tbl[i].b_cmd, tbl[i].exp_first_b);
    end

    // Input cmd change after grant must not reach the ALU
    c = mk_cmd(4'd3, 2'd1, 64'd0, 64'h1, 64'h55, 3'd0, 3'd0, 3'd0, 3'd0);
    @(negedge sys_clk);
    a_cmd = c;
    a_stb = 1'b1;
    sb.push_back('{1'b0, c});
    @(negedge sys_clk);                       // EXEC
    a_cmd = mk_cmd(4'd3, 2'd1, 64'd0, 64'h1, 64'hAA, 3'd0, 3'd0, 3'd0, 3'd0);
    #1;
    chk("iso_alu_o0", alu_o0, 64'h55);
    budget = 10;
    while (!a_ack && budget > 0) begin @(negedge sys_clk); budget--; end
    chk("iso_ack_seen", 64'(a_ack), 64'd1);
    a_stb = 1'b0;

    // Reset asserted for one edge during EXEC
    @(negedge sys_clk);
    a_cmd = mk_cmd(4'd12, 2'd2, 64'h9, 64'h9, 64'h9, 3'd1, 3'd1, 3'd1, 3'd1);
    a_stb = 1'b1;
    @(posedge sys_clk);                       // grant edge
    #1;
    sys_rst_n = 1'b0;
    a_stb     = 1'b0;
    @(posedge sys_clk);                       // reset edge while in EXEC
    #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_busy",   64'(busy),   64'd0);
    chk("mid_rst_res",    res,         64'd0);
    chk("mid_rst_flags",  64'(flags),  64'd0);
    chk("mid_rst_a_ack",  64'(a_ack),  64'd0);
    chk("mid_rst_op_cnt", 64'(op_cnt), 64'd0);
    repeat (3) @(negedge sys_clk);            // any stray ack is flagged by the scoreboard
    run_req(1'b1, 1'b0, mk_cmd(4'd12, 2'd2, 64'h9, 64'h9, 64'h9, 3'd1, 3'd1, 3'd1, 3'd1), '0, 1'b0);

    // Counter wrap: five back-to-back ops from reset -> 1,2,3,0,1
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      run_req(1'b1, 1'b0, mk_cmd(4'(k), 2'(k), 64'(k * 7), 64'(k + 100), 64'(k * 3 + 1),
                                 3'(k), 3'(k + 1), 3'(k + 2), 3'(k + 3)), '0, 1'b0);
    end
    @(negedge sys_clk);
    chk("wrap_op_cnt", 64'(op_cnt), 64'd1);
    chk("sb_drained",  64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mpu_alu_arb.md
Name: mpu_alu_arb

Overview:
Two-requester round-robin arbiter and sequencer in front of the shared combinational mpu_alu.
- Accepts a packed ALU command from requester A or B and drives it onto the ALU for one cycle.
- Registers res/flags and returns them with a one-cycle ack to the granted requester.
- Sits between the MPU fetch/decode units and the single mpu_alu instance.

Parameters:
CNT_W, 16, width of completed-operation counter op_cnt (wraps).

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset; synchronous, active-low
a_stb  in  1  requester A command valid; held until a_ack
a_cmd  in  210  requester A packed command (layout below)
a_ack  out  1  one-cycle completion pulse to A
b_stb  in  1  requester B command valid
b_cmd  in  210  requester B packed command
b_ack  out  1  one-cycle completion pulse to B
res  out  64  registered ALU result of last completed op
flags  out  8  registered ALU flags of last completed op
busy  out  1  high when state != IDLE
op_cnt  out  CNT_W  completed-operation count
alu_op  out  4  to mpu_alu.op
alu_size  out  2  to mpu_alu.size
alu_o0, alu_o1, alu_o2  out  64 each  to mpu_alu.o0/o1/o2
alu_s0, alu_s1, alu_s2, alu_sres  out  3 each  to mpu_alu.s0/s1/s2/sres
alu_res  in  64  from mpu_alu.res
alu_flags  in  8  from mpu_alu.flags

Behaviour:
- Clock and reset: single clock sys_clk; reset sys_rst_n is synchronous and active-low.
- Command layout: [209:206] op, [205:204] size, [203:140] o2, [139:76] o1, [75:12] o0, [11:9] s0, [8:6] s1, [5:3] s2, [2:0] sres.
- Reset (sys_rst_n=0 at edge):
  - state=IDLE; cmd register=0; so all alu_* outputs = 0.
  - res=0, flags=0, a_ack=b_ack=0, busy=0, op_cnt=0.
  - last-grant pointer = B, so A wins the first tie.
- FSM:
  - IDLE: if any stb is high, latch the winner's cmd into the cmd register, record grant, go to EXEC. Otherwise stay.
  - EXEC: alu_* are driven from the cmd register (stable the whole cycle). At the edge, capture alu_res→res and alu_flags→flags, assert the granted ack for the next cycle, op_cnt+1, go to DONE.
  - DONE: granted ack=1 (other ack=0). Next edge: ack→0, go to IDLE.
- Latency and throughput:
  - stb sampled at edge N → ack high during cycle after edge N+1 (2 cycles).
  - One op per 3 cycles max.
  - res/flags are valid while ack=1 and hold until the next EXEC capture.
- Arbitration:
  - Only one stb high → grant it.
  - Both high → grant the requester not granted last; pointer updates on grant.
  - The losing requester keeps stb high and is served next; no starvation.
- Handshake rules:
  - The requester must keep stb and cmd stable until ack.
  - It must drop stb at the edge where it samples ack=1. A stb still high in the IDLE cycle after DONE is a new request.
  - cmd changes while not granted are ignored until the grant edge; after the grant, the cmd register is isolated from the inputs.
  - stb dropped mid-operation does not abort; ack is still issued.
- Arithmetic:
  - op_cnt wraps from 2^CNT_W-1 to 0 with no flag.
  - No checking of op/size values; passed through verbatim.
- Reset mid-operation (EXEC or DONE): immediate return to IDLE, no ack, res/flags cleared, op_cnt cleared.
- alu_* outputs are purely the cmd register contents; they change only at grant edges and reset.

Test Plan:
- Single A request, cmd op=3, size=0, o0=0x54, o1=0x55, others 0 → alu_op=3, alu_o0=0x54 during EXEC; a_ack pulse 2 cycles after stb sampled; res/flags equal mpu_alu outputs for those operands; b_ack stays 0; op_cnt=1.
- A and B stb high in the same cycle after reset, A op=2 and B op=1 → A served first (a_ack), then B without gap beyond IDLE (b_ack 3 cycles later); alu_op sequence 2 then 1; op_cnt=2.
- Both held continuously for 4 ops → grants alternate A,B,A,B; busy never low for more than one cycle between ops.
- A changes a_cmd.o0 from 0x55 to 0xAA during EXEC → alu_o0 stays 0x55; res reflects 0x55 operand.
- sys_rst_n=0 for one edge while in EXEC → next cycle busy=0, res=0, flags=0, no ack, op_cnt=0; a request re-issued afterwards completes normally.
- CNT_W=2, 5 back-to-back ops → op_cnt reads 1,2,3,0,1.
